// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Purpose:
//   Round-robin arbiter that shares the single write port of an async FIFO
//   among NUM_REQ requesters in the write clock domain. One requester owns the
//   port at a time, for a burst of at most BURST_LEN words. The FIFO full flag
//   stalls the burst, so the FIFO is never written while full. After a burst
//   ends, one idle cycle precedes the next grant.
//
// Parameters:
//   NUM_REQ    - number of requesters (2..16)
//   Data_Width - FIFO data width
//   BURST_LEN  - maximum words per grant before re-arbitration (1..256)
//
// Ports:
//   wr_clk    in   write-domain clock, rising edge
//   wr_rst    in   synchronous reset, active-high
//   req       in   [NUM_REQ]            per-requester write request
//   req_data  in   [NUM_REQ*Data_Width] per-requester data, slice i = req[i]
//   ack       out  [NUM_REQ]            one-hot: word from requester i written
//   grant     out  [NUM_REQ]            one-hot registered owner, 0 when idle
//   busy      out                       high while a grant is active
//   full      in                        FIFO full flag
//   wr_en     out                       FIFO write enable
//   data_in   out  [Data_Width]         FIFO write data (0 while idle)
//   stall_cnt out  [16]                 only with FIFO_WR_ARB_STATS_EN defined:
//                                       saturating count of cycles in which the
//                                       owner wanted to write but full was set
//
// Build option:
//   `define FIFO_WR_ARB_STATS_EN to add the stall_cnt port and its counter.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int Data_Width = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*Data_Width-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  input  logic                          full,
  output logic                          wr_en,
  output logic [Data_Width-1:0]         data_in
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NUM_REQ_EXT = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;

  // ---------------------------------------------------------------------------
  // Per-requester data slices
  // ---------------------------------------------------------------------------
  logic [Data_Width-1:0] req_data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_data_arr[gi] = req_data[gi*Data_Width +: Data_Width];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin winner search starting at rr_ptr_q.
  // The loop walks the candidates from farthest to nearest so that the nearest
  // pending requester (in rotation order) is the last one written and wins.
  // ---------------------------------------------------------------------------
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     cand_sum;
  logic [IDX_W-1:0]   cand_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
      if (cand_sum >= NUM_REQ_EXT) begin
        cand_sum = cand_sum - NUM_REQ_EXT;
      end
      cand_idx = cand_sum[IDX_W-1:0];
      if (req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write-port datapath
  // ---------------------------------------------------------------------------
  logic               in_grant;
  logic               owner_req;
  logic [IDX_W-1:0]   next_ptr;

  assign in_grant  = (state_q == ST_GRANT);
  assign owner_req = req[gidx_q];

  // Reset gating keeps a mid-burst reset cycle from producing a write.
  assign wr_en   = in_grant & owner_req & ~full & ~wr_rst;
  // grant_q is one-hot on gidx_q while in GRANT, so it doubles as the ack mask.
  assign ack     = grant_q & {NUM_REQ{wr_en}};
  assign grant   = grant_q;
  assign busy    = in_grant;
  assign data_in = in_grant ? req_data_arr[gidx_q] : '0;

  // Pointer moves to the requester just after the one we served.
  assign next_ptr = (gidx_q == LAST_IDX) ? '0 : gidx_q + IDX_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gidx_d     = gidx_q;
    beat_cnt_d = beat_cnt_q;
    grant_d    = grant_q;

    unique case (state_q)
      ST_IDLE: begin
        // full is deliberately ignored here; a stalled owner simply waits
        // in GRANT.
        if (win_found) begin
          state_d    = ST_GRANT;
          gidx_d     = win_idx;
          grant_d    = NUM_REQ'(1) << win_idx;
          beat_cnt_d = '0;
        end
      end

      ST_GRANT: begin
        if (!owner_req) begin
          // Withdrawn: give up the port even if the burst is unfinished.
          state_d    = ST_IDLE;
          rr_ptr_d   = next_ptr;
          grant_d    = '0;
          beat_cnt_d = '0;
        end else if (wr_en) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = ST_IDLE;
            rr_ptr_d   = next_ptr;
            grant_d    = '0;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
        // Otherwise full is stalling the owner: hold everything.
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      beat_cnt_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Stall statistics: cycles where the owner had a word ready but full blocked
  // it. Saturates instead of wrapping so a long-running count stays meaningful.
  // ---------------------------------------------------------------------------
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_now;

  assign stall_now = in_grant & owner_req & full;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_now && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Purpose:
//   Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, Data_Width=8,
//   BURST_LEN=4). Directed scenarios with hand-computed expectations followed
//   by a random request/full stress phase with an in-order data scoreboard and
//   a bounded-wait fairness check. A monitor checks wr_en & full every cycle.
//   Define FIFO_WR_ARB_STATS_EN to also check stall_cnt.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NR    = 4;
  localparam int W     = 8;
  localparam int BL    = 4;
  localparam int BOUND = (NR - 1) * (BL + 1);

  logic              wr_clk;
  logic              wr_rst;
  logic [NR-1:0]     req;
  logic [NR*W-1:0]   req_data;
  logic [NR-1:0]     ack;
  logic [NR-1:0]     grant;
  logic              busy;
  logic              full;
  logic              wr_en;
  logic [W-1:0]      data_in;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0]       stall_cnt;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .Data_Width (W),
    .BURST_LEN  (BL)
  ) dut (
    .wr_clk    (wr_clk),
    .wr_rst    (wr_rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .grant     (grant),
    .busy      (busy),
    .full      (full),
    .wr_en     (wr_en),
    .data_in   (data_in)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_total = 0;
  int n_bad   = 0;
  bit mon_en  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled
  // after a further settle delay, well away from both clock edges.
  task automatic tick();
    @(posedge wr_clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // The FIFO must never be written while full, in any phase.
  always @(negedge wr_clk) begin
    if (mon_en) check_eq("no_wr_when_full", {31'd0, wr_en & full}, 32'd0);
  end

  int writes;
  int sent [NR];
  int rem  [NR];
  int waitc[NR];
  bit wact [NR];
  logic [NR-1:0] acked_last;
  logic stalled;

  initial begin
    wr_rst   = 1'b1;
    req      = '0;
    full     = 1'b0;
    req_data = '0;
    tick();
    tick();
    mon_en = 1'b1;

    // ---------------- reset state ----------------
    check_eq("rst_grant",   grant,   0);
    check_eq("rst_busy",    busy,    0);
    check_eq("rst_wr_en",   wr_en,   0);
    check_eq("rst_ack",     ack,     0);
    check_eq("rst_data_in", data_in, 0);

    // ---------------- reset mid-burst ----------------
    wr_rst = 1'b0;
    req = 4'b0001;
    req_data[7:0] = 8'h11;
    settle();
    check_eq("mid_idle_wr_en", wr_en, 0);
    tick(); settle();
    check_eq("mid_b0_grant", grant, 4'b0001);
    check_eq("mid_b0_ack",   ack,   4'b0001);
    check_eq("mid_b0_data",  data_in, 8'h11);
    tick(); settle();
    check_eq("mid_b1_ack",   ack,   4'b0001);
    tick();
    wr_rst = 1'b1;
    settle();
    check_eq("mid_rst_wr_en", wr_en, 0);
    check_eq("mid_rst_ack",   ack,   0);
    req = 4'b1111;
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = 8'h20 + 8'(i);
    tick();
    wr_rst = 1'b0;
    settle();
    check_eq("mid_after_grant", grant, 0);
    check_eq("mid_after_busy",  busy,  0);

    // ---------------- round-robin rotation (also proves rr_ptr=0) --------
    writes = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick(); settle();
      if (cyc % 5 == 4) begin
        check_eq("rr_gap_grant", grant, 0);
        check_eq("rr_gap_wr_en", wr_en, 0);
      end else begin
        check_eq("rr_grant", grant, 32'd1 << (cyc / 5));
        check_eq("rr_ack",   ack,   32'd1 << (cyc / 5));
        check_eq("rr_data",  data_in, 32'h20 + 32'(cyc / 5));
      end
      if (wr_en) begin
        writes++;
        $display("rr write: grant=%b data=%h", grant, data_in);
      end
    end
    check_eq("rr_writes_in_20", writes, 16);
    tick(); settle();
    check_eq("rr_wrap_grant", grant, 4'b0001);
    req = '0;
    settle();
    check_eq("rr_withdraw_wr_en", wr_en, 0);
    tick(); settle();
    check_eq("rr_exit_busy", busy, 0);

    // ---------------- single requester burst ----------------
    req = 4'b0100;
    req_data[2*W +: W] = 8'hA5;
    settle();
    check_eq("single_idle_wr_en", wr_en, 0);
    check_eq("single_idle_data",  data_in, 0);
    for (int b = 0; b < BL; b++) begin
      tick(); settle();
      check_eq("single_grant", grant, 4'b0100);
      check_eq("single_ack",   ack,   4'b0100);
      check_eq("single_data",  data_in, 8'hA5);
      $display("single write: beat=%0d ack=%b data=%h", b, ack, data_in);
    end
    tick(); settle();
    check_eq("single_gap_grant", grant, 0);
    check_eq("single_gap_wr_en", wr_en, 0);
    tick(); settle();
    check_eq("single_regrant", grant, 4'b0100);
    req = '0;
    settle();
    check_eq("single_withdraw_wr_en", wr_en, 0);
    tick(); settle();
    check_eq("single_exit_busy", busy, 0);

    // ---------------- full stall ----------------
    req = 4'b0010;
    req_data[1*W +: W] = 8'h5A;
    tick(); settle();
    check_eq("stall_b0_ack", ack, 4'b0010);
    tick(); settle();
    check_eq("stall_b1_ack", ack, 4'b0010);
    tick();
    full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      settle();
      check_eq("stall_wr_en", wr_en, 0);
      check_eq("stall_ack",   ack,   0);
      check_eq("stall_grant", grant, 4'b0010);
      tick();
    end
    full = 1'b0;
    settle();
    check_eq("stall_b2_ack",  ack, 4'b0010);
    check_eq("stall_b2_data", data_in, 8'h5A);
    tick(); settle();
    check_eq("stall_b3_ack", ack, 4'b0010);
    tick();
    req = '0;
    settle();
    check_eq("stall_exit_grant", grant, 0);
`ifdef FIFO_WR_ARB_STATS_EN
    check_eq("stall_cnt", stall_cnt, 5);
`endif

    // ---------------- withdrawal ----------------
    req = 4'b0011;
    req_data[0 +: W] = 8'h33;
    req_data[W +: W] = 8'h44;
    tick(); settle();
    check_eq("wd_grant0", grant, 4'b0001);
    check_eq("wd_ack0",   ack,   4'b0001);
    tick(); settle();
    check_eq("wd_ack1",   ack,   4'b0001);
    tick();
    req = 4'b0110;
    settle();
    check_eq("wd_drop_wr_en", wr_en, 0);
    check_eq("wd_drop_grant", grant, 4'b0001);
    tick(); settle();
    check_eq("wd_idle_grant", grant, 0);
    tick(); settle();
    check_eq("wd_next_grant", grant, 4'b0010);
    check_eq("wd_next_data",  data_in, 8'h44);
    req = '0;
    tick();
    tick();
    wr_rst = 1'b1;
    tick();
    wr_rst = 1'b0;

    // ---------------- random stress ----------------
    for (int i = 0; i < NR; i++) begin
      sent[i] = 0; rem[i] = 0; waitc[i] = 0; wact[i] = 1'b0;
    end
    acked_last = '0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (acked_last[i]) begin
          sent[i]++;
          rem[i]--;
          if (rem[i] == 0) req[i] = 1'b0;
        end
        if (!req[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b1;
          rem[i] = int'($urandom_range(1, 6));
        end
        req_data[i*W +: W] = {4'(i), 4'(sent[i])};
      end
      full = ($urandom_range(0, 3) == 0);
      #2;
      stalled = busy & full & (|(grant & req));
      check_eq("st_ack_onehot", {31'd0, $countones(ack) <= 1}, 1);
      for (int i = 0; i < NR; i++) begin
        if (ack[i]) begin
          check_eq("st_data_order", data_in, {24'd0, 4'(i), 4'(sent[i])});
          check_eq("st_ack_has_req", req[i], 1);
        end
        if (req[i] && !grant[i]) begin
          if (wact[i] && !stalled) waitc[i]++;
          wact[i] = 1'b1;
        end else begin
          if (grant[i] && wact[i])
            check_eq("st_wait_bounded", {31'd0, waitc[i] <= BOUND}, 1);
          wact[i]  = 1'b0;
          waitc[i] = 0;
        end
      end
      acked_last = ack;
    end
    for (int i = 0; i < NR; i++) begin
      $display("stress requester %0d: words written=%0d", i, sent[i]);
      check_eq("st_progress", {31'd0, sent[i] > 0}, 1);
    end

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Write-side round-robin arbiter that shares the single write port of the async FIFO (wr_en/data_in/full) among NUM_REQ requesters in the write clock domain. It grants one requester at a time for a burst of up to BURST_LEN words. It stalls on the FIFO full flag, so the FIFO is never written while full. The block sits directly in front of the FIFO write port and drives it.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
Data_Width, 8, FIFO data width
BURST_LEN, 4, maximum words per grant before re-arbitration (1..256)

Ports:
wr_clk  input  1  write-domain clock, all logic on rising edge
wr_rst  input  1  synchronous reset, active-high
req  input  NUM_REQ  per-requester write request, held until ack'd or withdrawn
req_data  input  NUM_REQ*Data_Width  per-requester write data; slice i belongs to req[i]
ack  output  NUM_REQ  one-hot pulse: word from requester i written this cycle
grant  output  NUM_REQ  one-hot registered current owner; 0 when idle
busy  output  1  high in GRANT state
full  input  1  FIFO full flag (write domain)
wr_en  output  1  FIFO write enable
data_in  output  Data_Width  FIFO write data

Behaviour:
- Reset (wr_rst high at an edge): state=IDLE, rr_ptr=0, beat_cnt=0, grant=0, busy=0.
- wr_en and ack are combinationally forced to 0 while wr_rst=1, so there is no write in the reset cycle, including mid-burst.
- States are IDLE and GRANT.
- IDLE:
  - wr_en=0, ack=0.
  - If |req, the winner is the first set req[i] searching i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Next edge: grant=onehot(winner), gidx=winner, beat_cnt=0, state=GRANT.
  - Arbitration latency is 1 cycle. full does not affect arbitration.
- GRANT:
  - wr_en = req[gidx] & ~full.
  - ack[gidx] = wr_en; all other ack bits are 0.
  - data_in = req_data[gidx]. data_in is don't-care when wr_en=0; it is driven 0 in IDLE.
  - Each wr_en cycle: beat_cnt increments.
  - Exit to IDLE when wr_en & beat_cnt==BURST_LEN-1 (burst done), or when req[gidx]==0 (withdrawn).
  - On exit: rr_ptr=(gidx+1) mod NUM_REQ, grant=0, beat_cnt=0.
  - full=1 with req[gidx]=1: the block holds GRANT, beat_cnt is unchanged, no timeout.
- Requester rule: req_data[i] is stable while req[i]=1. A word is consumed only in its ack cycle. Requesters may drop req at any time, including between beats.
- Back-to-back: after a burst ends, one IDLE cycle precedes the next grant. Worst-case throughput is BURST_LEN/(BURST_LEN+1).
- Fairness: after serving requester i, every other pending requester is served before i again.
- Invariant: wr_en & full is never 1. The bench checks this every cycle.
- beat_cnt width is clog2(BURST_LEN)+1. It never wraps, because exit occurs at BURST_LEN-1.

Optional Feature:
FIFO_WR_ARB_STATS_EN
- Defined: adds output stall_cnt [15:0], reset to 0.
  - Increments each cycle with state=GRANT & req[gidx] & full.
  - Saturates at 16'hFFFF.
  - Cleared only by wr_rst.
- Undefined: stall_cnt port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-burst: NUM_REQ=4, req=4'b0001, full=0; assert wr_rst during beat 2 -> wr_en=0 in the reset cycle; next cycle grant=0, busy=0, rr_ptr=0.
- Single requester burst: req=4'b0100, req_data[2]=8'hA5, full=0 -> grant=4'b0100 after 1 cycle. Then 4 ack[2] pulses with data_in=8'hA5, then 1 IDLE cycle, then re-grant to 2.
- Round-robin rotation: req=4'b1111 held, full=0 -> grant sequence 0001,0010,0100,1000,0001. Each grant gives 4 writes; 16 writes per 20 cycles.
- Full stall: granted requester 1 at beat 1; full=1 for 5 cycles -> wr_en=0, ack=0, grant held. After full=0, beats 2..3 complete. With FIFO_WR_ARB_STATS_EN: stall_cnt=5.
- Withdrawal: req=4'b0011, requester 0 granted; drop req[0] after 2 acks -> next cycle IDLE, then grant=4'b0010, rr_ptr=1 at exit.
- Random stress: random req/full over 10k cycles -> wr_en&full never 1. Per-requester ack counts match words sent in order. No requester waits more than (NUM_REQ-1)*(BURST_LEN+1) unstalled cycles.
